// File: rtl/bnn_lane_accumulator.sv
// bnn_lane_accumulator: XNOR-popcount neuron accumulator with a saturating, bias-preloaded sum and a valid/ready result
module bnn_lane_accumulator #(
  parameter int LANES     = 8,
  parameter int ACC_WIDTH = 12,
  parameter int BEAT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_first,
  input  logic                 in_last,
  input  logic [LANES-1:0]     in_x,
  input  logic [LANES-1:0]     in_w,
  input  logic [LANES-1:0]     in_mask,
  input  logic [ACC_WIDTH-1:0] in_bias,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic                 out_act,
  output logic                 out_sat,
  output logic [BEAT_W-1:0]    out_beats
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  localparam logic signed [ACC_WIDTH:0] ONE = (ACC_WIDTH+1)'(1);
  state_t state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d, clip;
  logic [BEAT_W-1:0] beats_q, beats_d;
  logic sat_q, sat_d, act_q, act_d, take, first, ovf;
  logic signed [ACC_WIDTH:0] delta, base, sum;
  always_comb begin
    delta = '0;
    for (int i = 0; i < LANES; i++)
      if (in_mask[i]) delta = (in_x[i] ^ in_w[i]) ? delta - ONE : delta + ONE;
  end
  // Sum is one bit wider than the accumulator; disagreeing top bits mean overflow, clipped toward the sign.
  always_comb begin
    take = in_valid & in_ready;
    first = (state_q == IDLE) | in_first;
    base = first ? {in_bias[ACC_WIDTH-1], in_bias} : {acc_q[ACC_WIDTH-1], acc_q};
    sum = base + delta;
    ovf = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
    clip = ovf ? {sum[ACC_WIDTH], {(ACC_WIDTH-1){~sum[ACC_WIDTH]}}} : sum[ACC_WIDTH-1:0];
    state_d = state_q;
    acc_d = acc_q;
    sat_d = sat_q;
    act_d = act_q;
    beats_d = beats_q;
    if (clr) begin
      state_d = IDLE;
      acc_d = '0;
      sat_d = 1'b0;
      act_d = 1'b0;
      beats_d = '0;
    end else if (take) begin
      state_d = in_last ? DONE : ACCUM;
      acc_d = clip;
      sat_d = (~first & sat_q) | ovf;
      act_d = ~clip[ACC_WIDTH-1];
      beats_d = first ? BEAT_W'(1) : beats_q + BEAT_W'(1);
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q <= '0;
      sat_q <= 1'b0;
      act_q <= 1'b0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      sat_q <= sat_d;
      act_q <= act_d;
      beats_q <= beats_d;
    end
  end
  assign in_ready = rst_n & (state_q != DONE);
  assign out_valid = state_q == DONE;
  assign out_sum = acc_q;
  assign out_act = act_q;
  assign out_sat = sat_q;
  assign out_beats = beats_q;
endmodule

// File: doc/bnn_lane_accumulator.md
Name: bnn_lane_accumulator

Overview:
Multi-lane binary-neuron accumulator: the parametrised successor to the single-bit add/sub ALU. Each beat XNOR-compares LANES input bits against LANES weight bits. It adds +1 per match and -1 per mismatch into a saturating signed accumulator preloaded with a bias. After the last beat it presents the neuron sum and sign activation through a valid/ready handshake. It sits between the input/weight buffers and the activation writeback in the NN datapath.

Parameters:
LANES, 8, bits compared per beat (>=1)
ACC_WIDTH, 12, signed accumulator/bias/sum width (>= clog2(LANES)+2)
BEAT_W, 8, width of beat counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous abort; returns to IDLE, drops partial sum
in_valid  input  1  beat valid
in_ready  output  1  beat accepted when in_valid & in_ready
in_first  input  1  beat is first of a neuron (load bias)
in_last  input  1  beat is last of a neuron
in_x  input  LANES  activation bits
in_w  input  LANES  weight bits
in_mask  input  LANES  lane enable; masked lanes contribute 0
in_bias  input  ACC_WIDTH  signed bias, sampled on the first beat
out_valid  output  1  result valid
out_ready  input  1  result consumed when out_valid & out_ready
out_sum  output  ACC_WIDTH  signed final sum
out_act  output  1  1 when out_sum >= 0, else 0
out_sat  output  1  saturation occurred during this neuron (sticky per neuron)
out_beats  output  BEAT_W  beats accepted for this neuron (wraps modulo 2^BEAT_W)

Behaviour:
- Reset (rst_n=0, async): state IDLE, accumulator 0, in_ready=0 during reset, out_valid=0, out_sum=0, out_act=0, out_sat=0, out_beats=0.
- States: IDLE, ACCUM, DONE. in_ready=1 in IDLE and ACCUM, 0 in DONE.
- Lane op: per lane i with in_mask[i]=1, op = in_x[i]^in_w[i]. op=0 gives +1; op=1 gives -1. The beat delta is the signed sum, range -LANES..+LANES.
- Accepted beat in IDLE: treated as first regardless of in_first. acc = sat(in_bias + delta), beats=1, sat flag = (clip occurred).
- Accepted beat in ACCUM with in_first=1: restart with the same rule as IDLE; the partial sum is discarded.
- Accepted beat in ACCUM with in_first=0: acc = sat(acc + delta), beats += 1, sat flag |= clip.
- Saturation: the result is clipped to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]. The addition is computed at ACC_WIDTH+1 bits before clipping.
- Transitions:
  - IDLE to ACCUM on an accepted beat with in_last=0.
  - IDLE or ACCUM to DONE on an accepted beat with in_last=1.
  - DONE to IDLE on out_valid & out_ready.
- Latency: out_valid rises on the clock edge that accepts the last beat, so it is visible the next cycle. Single-beat neurons (first&last) are legal and go IDLE to DONE directly.
- In DONE, out_sum, out_act, out_sat and out_beats are held stable until consumed. in_valid is ignored.
- out_act and out_sum are registered outputs, not combinational from the accumulator next-state.
- clr: highest priority except reset. Next state is IDLE, out_valid=0, and any beat presented the same cycle is dropped. clr in DONE discards the unconsumed result.
- A handshake in DONE with clr the same cycle: clr wins, the result is considered dropped.
- rst_n asserted mid-operation: immediate return to reset values; no partial output.
- in_bias is ignored on non-first beats.
- in_mask=0 on a beat: delta=0, but the beat still counts in out_beats.

Test Plan:
1. Single beat: in_first=1, in_last=1, bias=0, x=8'hFF, w=8'hFF, mask=8'hFF -> next cycle out_valid=1, out_sum=8, out_act=1, out_sat=0, out_beats=1.
2. Two beats: bias=3, each beat x=8'h00, w=8'hFF, mask=8'hFF -> out_sum=-13 (12'hFF3), out_act=0, out_beats=2.
3. Saturation:
   - bias=2040, one beat of +8 -> out_sum=2047, out_sat=1.
   - bias=-2045, one beat of -8 -> out_sum=-2048, out_sat=1.
   - Next neuron with bias=0, +8 -> out_sat=0.
4. Backpressure and zero result: one beat x=8'h0F, w=8'h00, mask=8'hFF, bias=0 -> sum 0, out_act=1. Hold out_ready=0 for 5 cycles -> out_valid stays 1, in_ready=0, outputs stable. out_ready=1 -> following cycle IDLE, in_ready=1.
5. Mask, restart and clr:
   - mask=8'h0F, x=8'h0F, w=8'h00, bias=0 -> delta -4.
   - A subsequent in_first=1 beat with bias=10, +8, last -> out_sum=18, out_beats=1.
   - Separately, clr asserted in ACCUM alongside a valid beat -> beat dropped, IDLE, no out_valid.
6. Async reset: drop rst_n between clock edges during ACCUM after 3 beats -> all outputs reset immediately. After release, a new single-beat neuron yields the correct result with out_beats=1.
